nn_forward_sequencer: RTL



---
 rtl/nn_pkg.sv | 39 +++
 rtl/nn_forward_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the 2-4-1 XOR forward-pass sequencer.
package nn_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned N_IN  = 2;
    localparam int unsigned N_HID = 4;

    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

    // Trained network parameters, stored as raw FP32 bit patterns.
    localparam logic [FP_W-1:0] W_IH [N_IN][N_HID] = '{
        '{32'h3EF59C31, 32'h40A1C4E1, 32'hC09E2C8A, 32'h3F2B1E3C},
        '{32'hBF1D4A6E, 32'h40A30C7A, 32'hC0A0F2B4, 32'h3E8C5A1F}
    };
    localparam logic [FP_W-1:0] W_HO [N_HID] = '{
        32'h3F0A3D71, 32'h40D4F8E1, 32'h40CC2A5D, 32'hBF3B6A7F
    };
    localparam logic [FP_W-1:0] B_H [N_HID] = '{
        32'h3D8F5C29, 32'hC0235B4A, 32'h401EC2D7, 32'hBE4C8B44
    };
    localparam logic [FP_W-1:0] B_O = 32'h3EA361BB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_ACC,
        ST_BIAS,
        ST_SIG,
        ST_STORE,
        ST_DONE
    } state_e;

    // Map an input pin level onto its FP32 encoding.
    function automatic logic [FP_W-1:0] fp_bit(input logic b);
        return b ? FP_ONE : FP_ZERO;
    endfunction

endpackage

// File: rtl/nn_forward_sequencer.sv
// Cycle-counted scheduler for the 2-4-1 XOR forward pass over one shared
// multiplier, adder and sigmoid unit. Only routes operands and samples results.
module nn_forward_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned SIG_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        p_1,
    input  logic        p_2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] res_m,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] res_a,
    output logic [31:0] sig_x,
    input  logic [31:0] res_s
);

    localparam int unsigned LAT_MAX = (MUL_LAT > ADD_LAT)
                                    ? ((MUL_LAT > SIG_LAT) ? MUL_LAT : SIG_LAT)
                                    : ((ADD_LAT > SIG_LAT) ? ADD_LAT : SIG_LAT);
    localparam int unsigned LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    localparam logic [LAT_W-1:0] MUL_END = LAT_W'(MUL_LAT - 1);
    localparam logic [LAT_W-1:0] ADD_END = LAT_W'(ADD_LAT - 1);
    // The sigmoid hold is split: SIG covers all but the final cycle, STORE is
    // the final cycle on whose edge res_s is captured.
    localparam logic [LAT_W-1:0] SIG_END   = LAT_W'((SIG_LAT >= 2) ? SIG_LAT - 2 : 0);
    localparam state_e           SIG_ENTRY = (SIG_LAT >= 2) ? ST_SIG : ST_STORE;

    state_e            state_q, state_d;
    logic              layer_q, layer_d;
    logic [1:0]        neuron_q, neuron_d;
    logic [1:0]        term_q, term_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [1:0]        x_q, x_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       hidden_q [N_HID];
    logic [31:0]       hidden_d [N_HID];
    logic [31:0]       out_q, out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0]       add_a_q, add_a_d, add_b_q, add_b_d;
    logic [31:0]       sig_x_q, sig_x_d;
    logic [1:0]        term_nx;
    logic              term_last;

    assign busy  = busy_q;
    assign done  = done_q;
    assign out   = out_q;
    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign add_a = add_a_q;
    assign add_b = add_b_q;
    assign sig_x = sig_x_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            layer_q  <= 1'b0;
            neuron_q <= '0;
            term_q   <= '0;
            lat_q    <= '0;
            x_q      <= '0;
            acc_q    <= FP_ZERO;
            for (int i = 0; i < int'(N_HID); i++) hidden_q[i] <= FP_ZERO;
            out_q    <= FP_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mul_a_q  <= FP_ZERO;
            mul_b_q  <= FP_ZERO;
            add_a_q  <= FP_ZERO;
            add_b_q  <= FP_ZERO;
            sig_x_q  <= FP_ZERO;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            term_q   <= term_d;
            lat_q    <= lat_d;
            x_q      <= x_d;
            acc_q    <= acc_d;
            hidden_q <= hidden_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            sig_x_q  <= sig_x_d;
        end
    end

    // Next-state logic; operands for a step are loaded on the edge entering it.
    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        neuron_d  = neuron_q;
        term_d    = term_q;
        lat_d     = lat_q;
        x_d       = x_q;
        acc_d     = acc_q;
        hidden_d  = hidden_q;
        out_d     = out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        sig_x_d   = sig_x_q;
        term_nx   = term_q + 2'd1;
        term_last = layer_q ? (term_q == 2'd3) : (term_q == 2'd1);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_MUL;
                    busy_d   = 1'b1;
                    x_d      = {p_2, p_1};
                    layer_d  = 1'b0;
                    neuron_d = '0;
                    term_d   = '0;
                    lat_d    = '0;
                    acc_d    = FP_ZERO;
                    mul_a_d  = fp_bit(p_1);
                    mul_b_d  = W_IH[0][0];
                end
            end
            ST_MUL: begin
                if (lat_q == MUL_END) begin
                    state_d = ST_ACC;
                    lat_d   = '0;
                    add_a_d = acc_q;
                    add_b_d = res_m;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_ACC: begin
                if (lat_q == ADD_END) begin
                    lat_d = '0;
                    acc_d = res_a;
                    if (term_last) begin
                        state_d = ST_BIAS;
                        add_a_d = res_a;
                        add_b_d = layer_q ? B_O : B_H[neuron_q];
                    end else begin
                        state_d = ST_MUL;
                        term_d  = term_nx;
                        mul_a_d = layer_q ? hidden_q[term_nx] : fp_bit(x_q[1]);
                        mul_b_d = layer_q ? W_HO[term_nx] : W_IH[1][neuron_q];
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_BIAS: begin
                if (lat_q == ADD_END) begin
                    state_d = SIG_ENTRY;
                    lat_d   = '0;
                    term_d  = '0;
                    acc_d   = res_a;
                    sig_x_d = res_a;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_SIG: begin
                if (lat_q == SIG_END) begin
                    state_d = ST_STORE;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_STORE: begin
                if (!layer_q) begin
                    hidden_d[neuron_q] = res_s;
                    state_d = ST_MUL;
                    acc_d   = FP_ZERO;
                    if (neuron_q == 2'd3) begin
                        layer_d  = 1'b1;
                        neuron_d = '0;
                        mul_a_d  = hidden_q[0];
                        mul_b_d  = W_HO[0];
                    end else begin
                        neuron_d = neuron_q + 2'd1;
                        mul_a_d  = fp_bit(x_q[0]);
                        mul_b_d  = W_IH[0][neuron_q + 2'd1];
                    end
                end else begin
                    state_d = ST_DONE;
                    out_d   = res_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
